silife_max7219_scanner: RTL and testbench
=========================================

# silife_max7219_scanner

Downstream readout stage for `silife_matrix_8x8`. It walks `row_select` across all 8 rows, captures each row's `cells`, and ships it to a MAX7219 LED driver as a 16-bit SPI word. After reset it runs a one-time MAX7219 configuration sequence. It then refreshes the display once per `refresh` request, so the board shows the live Game of Life generation.

## Interface
- `CLK_DIV`, default 2: SPI half-period in `clk` cycles; legal range ≥1.
- `INTENSITY`, default 4'h7: MAX7219 intensity register value.
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scanner run enable.
- `refresh`  in  1  single-cycle request to send one full frame (8 rows).
- `row_select`  out  3  row index driven to the matrix.
- `cells`  in  8  row contents returned by the matrix for `row_select`.
- `spi_cs_n`  out  1  MAX7219 LOAD/CS, active low.
- `spi_sclk`  out  1  SPI clock, mode 0, idle low.
- `spi_mosi`  out  1  SPI data, MSB first.
- `busy`  out  1  init or frame in progress.
- `frame_done`  out  1  one-cycle pulse after the 8th row word is latched.

## Operation
- FSM states: `IDLE`, `LOAD`, `SHIFT`, `LATCH`.
- Init and frame words both use the path LOAD → SHIFT → LATCH.
- A flag `init_done` is cleared only by reset.
- **Init sequence:** with `enable` high and `init_done` low, send 5 words in this order: 0x0F00 (test off), 0x0900 (no decode), 0x0B07 (scan limit 8), 0x0A0 concatenated with `INTENSITY` (intensity), 0x0C01 (normal operation). Then set `init_done`.
- **Frame:** sends rows r = 0..7. Each word is {4'h0, r+1, data}, where data[7-i] = `cells[i]` (column 0 maps to the leftmost LED).
- **LOAD:** lasts 1 cycle. Drive `row_select` = r. At the end of the cycle, capture `cells` and the word into the shift register.
- The matrix read path is combinational. `row_select` holds its value until the next LOAD.
- **Pending requests:** `refresh` sets a single pending bit. A refresh arriving while busy, or during init, is held and served afterwards. Further refreshes during that time merge into the same bit and are not counted.
- **`enable` low:** the current word always completes; no truncated SPI frame is ever sent. The FSM then returns to IDLE and clears the pending bit. If init was unfinished, it restarts from word 0 when `enable` returns.
- **Reset mid-word:** `spi_cs_n` goes high and the FSM goes to IDLE immediately (asynchronous). Init reruns afterwards.
- **Reset values:** `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0, `row_select`=0, `busy`=0, `frame_done`=0.

## Timing
- **Per word:** 1 LOAD cycle + 16 bits × 2·CLK_DIV + CLK_DIV LATCH = 1 + 33·CLK_DIV cycles.
- With `CLK_DIV`=2 a word takes 67 cycles and a frame takes 536 cycles.
- `spi_cs_n` falls in the first SHIFT cycle and stays low across all 16 bits.
- Each bit has a low phase of CLK_DIV cycles, with `spi_mosi` valid, followed by a high phase of CLK_DIV cycles.
- `spi_mosi` changes only while `spi_sclk` is low.
- After the 16th high phase, `spi_sclk` returns low and `spi_cs_n` rises in the same cycle. `spi_cs_n` then stays high for CLK_DIV cycles (LATCH).
- `busy` rises in the cycle after a `refresh` is accepted, or after reset release when `enable`=1.
- `busy` falls in the same cycle that `frame_done` pulses. For init without a pending refresh, `busy` falls at the end of init and no `frame_done` is issued.
- Back-to-back frames: a pending refresh starts its LOAD in the cycle after `frame_done`, with no idle cycle.

## Structure
- Package `silife_max7219_pkg` holds:
  - the MAX7219 register addresses (0x09–0x0C, 0x0F);
  - the init word ROM (5 × 16-bit) and `INIT_WORDS`=5;
  - the FSM state enum.
- Sub-module `silife_spi_word_tx` holds the 16-bit shifter, the CLK_DIV divider, and `cs_n`/`sclk` generation, with a start/done handshake.
- The top-level module holds the FSM, the row counter, the init counter and the pending-refresh logic.

## Test plan
- **Reset:** hold `reset`. All outputs must show their reset values. Release with `enable`=1 → exactly 5 CS-low frames, decoding to 0x0F00, 0x0900, 0x0B07, 0x0A07, 0x0C01. Then `busy`=0 and no `frame_done`.
- **Frame content:** after init, the matrix holds 0x70 in row 4 and 0 elsewhere. Pulse `refresh` → 8 words 0x0100…0x0800, except the fifth word, which must be 0x050E. `frame_done` pulses 536 cycles after LOAD of row 0 (`CLK_DIV`=2).
- **Request merging:** pulse `refresh` three times during a frame → exactly one further frame, starting the cycle after `frame_done`.
- **Enable drop:** drop `enable` in the middle of bit 7 of row 2 → that word completes with 16 clean edges and `spi_cs_n` rises. No row-3 word is sent. `busy`=0.
- **Reset mid-word:** assert `reset` during SHIFT → `spi_cs_n`=1 and `spi_sclk`=0 immediately. After release, the full 5-word init repeats.
- **SPI timing:** with `CLK_DIV`=1, check every SCLK high and low phase is 1 cycle, `spi_mosi` is stable around each rising edge, and the word period is 34 cycles.

Source files
------------

// File: rtl/silife_max7219_pkg.sv
// Shared definitions for the MAX7219 readout path of the silife matrix.
// Register map, init word ROM and the scanner FSM state type.
package silife_max7219_pkg;

    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCAN      = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam int INIT_WORDS = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } state_e;

    function automatic logic [15:0] init_rom(
        input logic [2:0] idx,
        input logic [3:0] intensity
    );
        logic [15:0] w;
        w = 16'h0000;
        case (idx)
            3'd0:    w = {REG_TEST, 8'h00};
            3'd1:    w = {REG_DECODE, 8'h00};
            3'd2:    w = {REG_SCAN, 8'h07};
            3'd3:    w = {REG_INTENSITY, 4'h0, intensity};
            3'd4:    w = {REG_SHUTDOWN, 8'h01};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Column 0 drives the leftmost LED, which is the digit MSB.
    function automatic logic [7:0] col_reverse(input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[7-i] = c[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/silife_spi_word_tx.sv
// 16-bit SPI mode-0 word transmitter with CS framing and latch gap.
// start_i captures the word; done_o marks the last latch-gap cycle.
module silife_spi_word_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] word_i,
    output logic        cs_n_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        shift_last_o,
    output logic        done_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic          active_q, active_d;
    logic          latch_q, latch_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    half_q, half_d;
    logic [15:0]   sr_q, sr_d;
    logic          tick;

    assign tick = (div_q == DIV_MAX);

    always_comb begin
        active_d = active_q;
        latch_d  = latch_q;
        div_d    = div_q;
        half_d   = half_q;
        sr_d     = sr_q;
        if (start_i) begin
            active_d = 1'b1;
            latch_d  = 1'b0;
            div_d    = '0;
            half_d   = 5'd0;
            sr_d     = word_i;
        end else if (active_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                half_d = half_q + 5'd1;
                // Shift at the end of the high phase so MOSI moves while SCLK is low.
                if (half_q[0]) begin
                    sr_d = {sr_q[14:0], 1'b0};
                end
                if (half_q == 5'd31) begin
                    active_d = 1'b0;
                    latch_d  = 1'b1;
                end
            end
        end else if (latch_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                latch_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            latch_q  <= 1'b0;
            div_q    <= '0;
            half_q   <= 5'd0;
            sr_q     <= 16'h0000;
        end else begin
            active_q <= active_d;
            latch_q  <= latch_d;
            div_q    <= div_d;
            half_q   <= half_d;
            sr_q     <= sr_d;
        end
    end

    assign cs_n_o       = ~active_q;
    assign sclk_o       = active_q & half_q[0];
    assign mosi_o       = active_q & sr_q[15];
    assign shift_last_o = active_q & tick & (half_q == 5'd31);
    assign done_o       = latch_q & tick;

endmodule

// File: rtl/silife_max7219_scanner.sv
// Scans the 8x8 life matrix row by row into a MAX7219 over SPI.
// Runs the one-time display init, then one frame per refresh request.
module silife_max7219_scanner
    import silife_max7219_pkg::*;
#(
    parameter int         CLK_DIV   = 2,
    parameter logic [3:0] INTENSITY = 4'h7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       refresh,
    output logic [2:0] row_select,
    input  logic [7:0] cells,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       busy,
    output logic       frame_done
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  row_sel_q, row_sel_d;
    logic        init_done_q, init_done_d;
    logic        pend_q, pend_d;
    logic        fdone_q, fdone_d;
    logic        tx_start, tx_shift_last, tx_done;
    logic [3:0]  digit;
    logic [15:0] word;

    assign digit    = {1'b0, idx_q} + 4'd1;
    assign tx_start = (state_q == LOAD);
    assign word     = init_done_q
                    ? {4'h0, digit, col_reverse(cells)}
                    : init_rom(idx_q, INTENSITY);

    // The matrix read is combinational, so the row must be on the bus during LOAD.
    assign row_select = (tx_start && init_done_q) ? idx_q : row_sel_q;
    assign row_sel_d  = row_select;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        pend_d      = pend_q | refresh;
        fdone_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!enable) begin
                    pend_d = 1'b0;
                end else if (!init_done_q) begin
                    state_d = LOAD;
                    idx_d   = 3'd0;
                end else if (pend_d) begin
                    state_d = LOAD;
                    idx_d   = 3'd0;
                    pend_d  = 1'b0;
                end
            end
            LOAD: state_d = SHIFT;
            SHIFT: begin
                if (tx_shift_last) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                if (tx_done) begin
                    if (!enable) begin
                        state_d = IDLE;
                        idx_d   = 3'd0;
                        pend_d  = 1'b0;
                    end else if (!init_done_q) begin
                        if (idx_q == 3'(INIT_WORDS - 1)) begin
                            init_done_d = 1'b1;
                            idx_d       = 3'd0;
                            state_d     = pend_d ? LOAD : IDLE;
                            pend_d      = 1'b0;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = LOAD;
                        end
                    end else if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        fdone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            row_sel_q   <= 3'd0;
            init_done_q <= 1'b0;
            pend_q      <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_sel_q   <= row_sel_d;
            init_done_q <= init_done_d;
            pend_q      <= pend_d;
            fdone_q     <= fdone_d;
        end
    end

    silife_spi_word_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk          (clk),
        .reset        (reset),
        .start_i      (tx_start),
        .word_i       (word),
        .cs_n_o       (spi_cs_n),
        .sclk_o       (spi_sclk),
        .mosi_o       (spi_mosi),
        .shift_last_o (tx_shift_last),
        .done_o       (tx_done)
    );

    assign busy       = (state_q != IDLE);
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_silife_max7219_scanner.sv
// Scoreboard bench for the MAX7219 scanner: SPI words decoded by a
// monitor and compared against words predicted from the matrix contents.
module tb_silife_max7219_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, refresh;
    logic [7:0] cells;
    logic [2:0] row_select;
    logic       spi_cs_n, spi_sclk, spi_mosi, busy, frame_done;

    logic       rst_f;
    logic [2:0] rs_f;
    logic       cs_f, sclk_f, mosi_f, busy_f, fd_f;

    logic [7:0]  mat [8];
    logic [15:0] init_exp [5];

    assign cells = mat[row_select];

    silife_max7219_scanner #(.CLK_DIV(2), .INTENSITY(4'h7)) dut (
        .clk(clk), .reset(reset), .enable(enable), .refresh(refresh),
        .row_select(row_select), .cells(cells), .spi_cs_n(spi_cs_n),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .busy(busy),
        .frame_done(frame_done)
    );

    silife_max7219_scanner #(.CLK_DIV(1), .INTENSITY(4'h7)) dut_fast (
        .clk(clk), .reset(rst_f), .enable(1'b1), .refresh(1'b0),
        .row_select(rs_f), .cells(8'h00), .spi_cs_n(cs_f),
        .spi_sclk(sclk_f), .spi_mosi(mosi_f), .busy(busy_f),
        .frame_done(fd_f)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] exp_q [$];
    int nwords = 0;
    int bitcnt = 0;
    int fd_cnt = 0;
    int fd_cycles [$];
    int br_cycles [$];
    int fwords = 0;

    function automatic void chk(input bit ok, input string nm,
                                input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [15:0] row_word(input int r, input logic [7:0] c);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[7-i] = c[i];
        return {4'h0, 4'(r + 1), d};
    endfunction

    task automatic push_frame(input int rows);
        for (int r = 0; r < rows; r++) exp_q.push_back(row_word(r, mat[r]));
    endtask

    task automatic push_init();
        for (int i = 0; i < 5; i++) exp_q.push_back(init_exp[i]);
    endtask

    task automatic pulse_refresh();
        @(posedge clk); #1 refresh = 1'b1;
        @(posedge clk); #1 refresh = 1'b0;
    endtask

    task automatic wait_words(input int n, input int lim, input string nm);
        int k = 0;
        while (nwords < n && k < lim) begin @(negedge clk); k++; end
        chk(nwords >= n, nm, nwords, n);
    endtask

    task automatic wait_fd(input int n, input int lim, input string nm);
        int k = 0;
        while (fd_cnt < n && k < lim) begin @(negedge clk); k++; end
        chk(fd_cnt >= n, nm, fd_cnt, n);
    endtask

    // Main SPI monitor
    initial begin
        logic pcs, psclk, pbusy;
        logic [15:0] sr, e;
        pcs = 1'b1; psclk = 1'b0; pbusy = 1'b0; sr = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pcs = 1'b1; psclk = 1'b0; pbusy = 1'b0; bitcnt = 0;
            end else begin
                if (!spi_cs_n && pcs) begin bitcnt = 0; sr = 16'h0; end
                if (!spi_cs_n && spi_sclk && !psclk) begin
                    sr = {sr[14:0], spi_mosi};
                    bitcnt++;
                end
                if (spi_cs_n && !pcs) begin
                    chk(bitcnt == 16, "bit_count", bitcnt, 16);
                    chk(!spi_sclk, "sclk_low_at_cs_rise", spi_sclk, 0);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_word", sr, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(sr == e, "spi_word", sr, e);
                    end
                    nwords++;
                end
                if (busy && !pbusy) br_cycles.push_back(cyc);
                if (frame_done) begin
                    fd_cnt++;
                    fd_cycles.push_back(cyc);
                    chk(!busy, "busy_at_frame_done", busy, 0);
                end
                pcs = spi_cs_n; psclk = spi_sclk; pbusy = busy;
            end
        end
    end

    // CLK_DIV=1 timing monitor
    initial begin
        logic fcs, fsclk, fmosi;
        logic [15:0] fsr;
        int frun, fbit, flast;
        fcs = 1'b1; fsclk = 1'b0; fmosi = 1'b0; fsr = 16'h0;
        frun = 0; fbit = 0; flast = -1;
        forever begin
            @(negedge clk);
            if (!rst_f) begin
                if (!cs_f && fcs) begin
                    frun = 1; fbit = 0; fsr = 16'h0;
                    if (flast >= 0) chk(cyc - flast == 34, "word_period", cyc - flast, 34);
                    flast = cyc;
                end else if (!cs_f) begin
                    if (sclk_f != fsclk) begin
                        chk(frun == 1, fsclk ? "sclk_high_len" : "sclk_low_len", frun, 1);
                        frun = 1;
                    end else begin
                        frun++;
                    end
                end else if (cs_f && !fcs) begin
                    chk(frun == 1, "sclk_last_high_len", frun, 1);
                    chk(fbit == 16, "fast_bit_count", fbit, 16);
                    if (fwords < 5) chk(fsr == init_exp[fwords], "fast_word", fsr, init_exp[fwords]);
                    else chk(1'b0, "fast_unexpected_word", fsr, 0);
                    fwords++;
                end
                if (!cs_f && sclk_f && !fsclk) begin
                    chk(mosi_f == fmosi, "mosi_stable", mosi_f, fmosi);
                    fsr = {fsr[14:0], mosi_f};
                    fbit++;
                end
                fcs = cs_f; fsclk = sclk_f; fmosi = mosi_f;
            end
        end
    end

    initial begin
        int base_w, base_fd, k;
        init_exp[0] = 16'h0F00; init_exp[1] = 16'h0900; init_exp[2] = 16'h0B07;
        init_exp[3] = 16'h0A07; init_exp[4] = 16'h0C01;
        reset = 1'b1; rst_f = 1'b1; enable = 1'b0; refresh = 1'b0;
        for (int r = 0; r < 8; r++) mat[r] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk(spi_cs_n == 1'b1, "reset_cs_n", spi_cs_n, 1);
        chk(spi_sclk == 1'b0, "reset_sclk", spi_sclk, 0);
        chk(spi_mosi == 1'b0, "reset_mosi", spi_mosi, 0);
        chk(row_select == 3'd0, "reset_row_select", row_select, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(frame_done == 1'b0, "reset_frame_done", frame_done, 0);

        push_init();
        enable = 1'b1; reset = 1'b0; rst_f = 1'b0;
        wait_words(5, 1000, "init_words");
        repeat (6) @(posedge clk);
        #1;
        chk(busy == 1'b0, "busy_after_init", busy, 0);
        chk(fd_cnt == 0, "no_frame_done_init", fd_cnt, 0);
        chk(exp_q.size() == 0, "init_queue_empty", exp_q.size(), 0);

        mat[4] = 8'h70;
        push_frame(8);
        pulse_refresh();
        wait_fd(1, 1200, "frame1_done");
        chk(fd_cycles[0] - br_cycles[br_cycles.size()-1] == 536, "frame_len",
            fd_cycles[0] - br_cycles[br_cycles.size()-1], 536);
        chk(exp_q.size() == 0, "frame1_queue_empty", exp_q.size(), 0);

        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < 8; r++) mat[r] = 8'($urandom);
            base_fd = fd_cnt;
            push_frame(8);
            pulse_refresh();
            wait_fd(base_fd + 1, 1200, "rand_frame_done");
            repeat (3) @(posedge clk);
        end

        for (int r = 0; r < 8; r++) mat[r] = 8'($urandom);
        base_fd = fd_cnt;
        push_frame(8);
        push_frame(8);
        pulse_refresh();
        repeat (50) @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            pulse_refresh();
            repeat ($urandom_range(20, 80)) @(posedge clk);
        end
        wait_fd(base_fd + 2, 2500, "merged_frames_done");
        repeat (700) @(posedge clk);
        #1;
        chk(fd_cnt == base_fd + 2, "merged_frame_count", fd_cnt, base_fd + 2);
        chk(br_cycles[br_cycles.size()-1] == fd_cycles[base_fd] + 1, "back_to_back",
            br_cycles[br_cycles.size()-1], fd_cycles[base_fd] + 1);
        chk(exp_q.size() == 0, "merged_queue_empty", exp_q.size(), 0);

        base_w = nwords; base_fd = fd_cnt;
        for (int r = 0; r < 8; r++) mat[r] = 8'($urandom);
        push_frame(3);
        pulse_refresh();
        k = 0;
        while (!(nwords == base_w + 2 && bitcnt == 7) && k < 400) begin @(negedge clk); k++; end
        chk(k < 400, "reach_row2_bit7", k, 400);
        @(posedge clk);
        #1 enable = 1'b0;
        k = 0;
        while (busy && k < 200) begin @(negedge clk); k++; end
        repeat (150) @(posedge clk);
        #1;
        chk(nwords == base_w + 3, "enable_drop_words", nwords - base_w, 3);
        chk(busy == 1'b0, "enable_drop_busy", busy, 0);
        chk(fd_cnt == base_fd, "enable_drop_no_fd", fd_cnt, base_fd);
        chk(exp_q.size() == 0, "enable_drop_queue", exp_q.size(), 0);
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk(busy == 1'b0, "no_resume_after_enable", busy, 0);

        push_frame(8);
        pulse_refresh();
        k = 0;
        while (!(!spi_cs_n && bitcnt >= 3) && k < 300) begin @(negedge clk); k++; end
        chk(k < 300, "reach_mid_word", k, 300);
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        chk(spi_cs_n == 1'b1, "rst_mid_cs_n", spi_cs_n, 1);
        chk(spi_sclk == 1'b0, "rst_mid_sclk", spi_sclk, 0);
        chk(busy == 1'b0, "rst_mid_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        base_w = nwords;
        push_init();
        reset = 1'b0;
        wait_words(base_w + 5, 1000, "reinit_words");
        repeat (6) @(posedge clk);
        #1;
        chk(busy == 1'b0, "busy_after_reinit", busy, 0);
        chk(exp_q.size() == 0, "reinit_queue_empty", exp_q.size(), 0);
        chk(fwords == 5, "fast_word_count", fwords, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
